// File: rtl/audio_pkg.sv
// Shared audio types for the ADC receiver, DAC serializer and DSP channel strip.
package audio_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S master clock generator: BCLK/LRCK from the system clock plus edge
// strobes and the bit index within the current channel slot.
module i2s_clk_gen #(
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_HALF  = 2
) (
  input  logic                          clk_12,
  input  logic                          reset_n,
  input  logic                          enable,
  output logic                          bclk,
  output logic                          lrck,
  output logic                          bclk_rise,
  output logic                          bclk_fall,
  output logic [$clog2(SLOT_WIDTH)-1:0] slot_idx
);
  localparam int KW    = $clog2(SLOT_WIDTH);
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_W   = BIT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             wrap;

  // Strobes fire in the cycle whose clock edge toggles bclk.
  assign wrap        = enable && (div_cnt == DIV_LAST);
  assign bclk_rise   = wrap && !bclk;
  assign bclk_fall   = wrap && bclk;
  assign bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  // lrck always mirrors (bit_cnt >= SLOT_WIDTH), so it selects the slot offset.
  assign slot_idx    = KW'(lrck ? (bit_cnt - SLOT_W) : bit_cnt);

  // Divider, bit clock and frame position; disable parks everything at frame start.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) bclk <= ~bclk;
      if (bclk_fall) begin
        bit_cnt <= bit_cnt_nxt;
        lrck    <= (bit_cnt_nxt >= SLOT_W);
      end
    end
  end

endmodule

// File: rtl/adc_i2s_rx.sv
// I2S master receiver for the stereo ADC: deserializes MSB-first samples and
// publishes one left/right pair per frame on a valid/ready interface.
module adc_i2s_rx
  import audio_pkg::*;
#(
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_HALF  = 2
) (
  input  logic    clk_12,
  input  logic    reset_n,
  input  logic    enable,
  input  logic    adc_data,
  output logic    bclk,
  output logic    lrck,
  output sample_t left_out,
  output sample_t right_out,
  output logic    out_valid,
  input  logic    out_ready,
  output logic    overrun
);
  localparam int KW = $clog2(SLOT_WIDTH);
  localparam logic [KW-1:0] K_FIRST = KW'(1);
  localparam logic [KW-1:0] K_LAST  = KW'(SAMPLE_WIDTH);

  // The MSB sits one BCLK after the LRCK edge, so a sample needs SAMPLE_WIDTH+1 slot bits.
  if (SAMPLE_WIDTH > SLOT_WIDTH - 1) begin : g_width_chk
    $error("adc_i2s_rx: SAMPLE_WIDTH must not exceed SLOT_WIDTH-1");
  end

  logic          bclk_rise;
  logic          bclk_fall_unused;  // falling strobe serves the DAC path only
  logic [KW-1:0] slot_idx;

  i2s_clk_gen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_HALF  (BCLK_HALF)
  ) u_clk_gen (
    .clk_12    (clk_12),
    .reset_n   (reset_n),
    .enable    (enable),
    .bclk      (bclk),
    .lrck      (lrck),
    .bclk_rise (bclk_rise),
    .bclk_fall (bclk_fall_unused),
    .slot_idx  (slot_idx)
  );

  sample_t shift_q, shift_nxt, left_hold;
  stereo_t pair_q;
  logic    pub_q, capture, slot_last;

  // ADC launches on the BCLK fall, so the bit is stable at the following rise.
  assign capture   = bclk_rise && (slot_idx >= K_FIRST) && (slot_idx <= K_LAST);
  assign slot_last = capture && (slot_idx == K_LAST);
  assign shift_nxt = {shift_q[SAMPLE_WIDTH-2:0], adc_data};
  assign left_out  = pair_q.left;
  assign right_out = pair_q.right;

  // Capture, left hold, pair publish and output handshake.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      left_hold <= '0;
      pub_q     <= 1'b0;
      pair_q    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Output side keeps running across enable=0 so a held pair can still drain.
      overrun <= pub_q && out_valid && !out_ready;
      if (pub_q) begin
        pair_q.left  <= left_hold;
        pair_q.right <= shift_q;
        out_valid    <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (!enable) begin
        shift_q   <= '0;
        left_hold <= '0;
        pub_q     <= 1'b0;
      end else begin
        pub_q <= slot_last && lrck;
        if (capture) shift_q <= shift_nxt;
        if (slot_last && !lrck) left_hold <= shift_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adc_i2s_rx.sv
// Bench for adc_i2s_rx: behavioural I2S ADC model driving frames from a
// vector table, scoreboard of expected pairs, plus timing corner sequences.
module tb_adc_i2s_rx;
  import audio_pkg::*;

  logic    clk_12, reset_n, enable, adc_data, out_ready;
  logic    bclk, lrck, out_valid, overrun;
  sample_t left_out, right_out;

  adc_i2s_rx dut (
    .clk_12    (clk_12),
    .reset_n   (reset_n),
    .enable    (enable),
    .adc_data  (adc_data),
    .bclk      (bclk),
    .lrck      (lrck),
    .left_out  (left_out),
    .right_out (right_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  typedef struct {
    logic [15:0] l_bits;
    logic [15:0] r_bits;
    int          exp_l;
    int          exp_r;
  } vec_t;

  vec_t vecs[6];
  vec_t exp_q[$];
  int   stim_q[$];
  int   pub_cyc_q[$];
  int   cyc, pub_cnt, ovr_cnt, chk_cnt, pass_cnt;

  initial begin
    clk_12 = 1'b0;
    forever #5 clk_12 = ~clk_12;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_12);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d required finish", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %0d, expected %0d", name, $signed(got), $signed(exp));
    else
      pass_cnt++;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bclk;
      1:       return lrck;
      2:       return out_valid;
      default: return overrun;
    endcase
  endfunction

  // Polls away from the active edge until the selected output reaches val.
  task automatic wait_level(input int sel, input logic val, input int budget, output int at);
    int n;
    at = -1;
    n  = 0;
    while (at < 0 && n < budget) begin
      @(negedge clk_12); #1;
      n++;
      if (sig(sel) === val) at = cyc;
    end
    if (at < 0) begin
      chk_cnt++;
      $display("FAIL wait_sig%0d: got timeout, expected level %0b", sel, val);
    end
  endtask

  task automatic wait_pubs(input int target, input int budget);
    int n;
    n = 0;
    while (pub_cnt < target && n < budget) begin
      @(negedge clk_12); #1;
      n++;
    end
    if (pub_cnt < target) begin
      chk_cnt++;
      $display("FAIL wait_pubs: got %0d pairs, expected %0d", pub_cnt, target);
    end
  endtask

  function automatic logic slot_bit(input logic [15:0] s, input int k);
    if (k >= 1 && k <= 16) return s[16 - k];
    return 1'b1;  // padding
  endfunction

  // ADC model: tracks BCLK falls, drives the next bit, queues the pair once its last bit is out.
  initial begin : adc_model
    bit   prev_bclk, prev_lrck, fresh;
    int   k;
    vec_t cur;
    prev_bclk = 1'b0;
    prev_lrck = 1'b0;
    fresh     = 1'b1;
    k         = 0;
    cur       = '{16'h0, 16'h0, 0, 0};
    adc_data  = 1'b1;
    forever begin
      @(negedge clk_12);
      if (!reset_n || !enable) begin
        fresh    = 1'b1;
        k        = 0;
        adc_data = 1'b1;
      end else begin
        if (fresh) begin
          if (stim_q.size() > 0) cur = vecs[stim_q.pop_front()];
          fresh = 1'b0;
        end
        if (prev_bclk && !bclk) begin
          if (lrck != prev_lrck) begin
            k = 0;
            if (!lrck && stim_q.size() > 0) cur = vecs[stim_q.pop_front()];
          end else begin
            k++;
          end
          adc_data = slot_bit(lrck ? cur.r_bits : cur.l_bits, k);
          if (lrck && k == 16) exp_q.push_back(cur);
        end
      end
      prev_bclk = bclk;
      prev_lrck = lrck;
    end
  end

  // Monitor: a publish is a rising out_valid or an overrun pulse.
  initial begin : monitor
    bit   prev_valid;
    vec_t e;
    prev_valid = 1'b0;
    pub_cnt    = 0;
    ovr_cnt    = 0;
    forever begin
      @(negedge clk_12);
      if (reset_n === 1'b1 && ((out_valid && !prev_valid) || overrun)) begin
        pub_cnt++;
        pub_cyc_q.push_back(cyc);
        if (overrun) ovr_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_pair: got L=%0d R=%0d, expected no pair", left_out, right_out);
        end else begin
          e = exp_q.pop_front();
          check("left_out", 32'(left_out), e.exp_l);
          check("right_out", 32'(right_out), e.exp_r);
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin : main
    int t0, t1, t2, c, pc0, ov0;
    chk_cnt  = 0;
    pass_cnt = 0;
    vecs[0] = '{16'h8001, 16'h7FFE, -32767, 32766};
    vecs[1] = '{16'h0001, 16'hFFFF, 1, -1};
    vecs[2] = '{16'h1234, 16'hEDCB, 4660, -4661};
    vecs[3] = '{16'h0000, 16'h8000, 0, -32768};
    vecs[4] = '{16'h7FFF, 16'h5A5A, 32767, 23130};
    vecs[5] = '{16'hA5A5, 16'h0F0F, -23131, 3855};

    reset_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk_12);
    #1;
    check("rst_bclk", bclk, 0);
    check("rst_lrck", lrck, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_left", 32'(left_out), 0);
    check("rst_right", 32'(right_out), 0);

    // Streaming frames with the consumer always ready.
    for (int i = 0; i < 3; i++) stim_q.push_back(i);
    reset_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
    c = cyc;
    wait_level(0, 1'b0, 10, t0);
    wait_level(0, 1'b1, 10, t0);
    wait_level(0, 1'b0, 10, t1);
    wait_level(0, 1'b1, 10, t2);
    check("bclk_period", t2 - t0, 4);
    check("bclk_high", t1 - t0, 2);
    wait_level(1, 1'b1, 300, t0);
    wait_level(1, 1'b0, 300, t1);
    wait_level(1, 1'b1, 300, t2);
    check("lrck_period", t2 - t0, 256);
    check("lrck_high", t1 - t0, 128);
    wait_pubs(3, 1000);
    if (pub_cyc_q.size() >= 3) begin
      check("first_latency", pub_cyc_q[0] - c, 195);
      check("pair_spacing1", pub_cyc_q[1] - pub_cyc_q[0], 256);
      check("pair_spacing2", pub_cyc_q[2] - pub_cyc_q[1], 256);
    end
    check("no_overrun", ovr_cnt, 0);
    @(negedge clk_12); #1;
    check("valid_pulse", out_valid, 0);

    // Consumer stalls for two frames: held pair, then overrun on the second.
    stim_q.push_back(3);
    stim_q.push_back(4);
    out_ready = 1'b0;
    pc0 = pub_cnt;
    ov0 = ovr_cnt;
    wait_pubs(pc0 + 1, 400);
    repeat (100) @(negedge clk_12);
    #1;
    check("valid_held", out_valid, 1);
    wait_pubs(pc0 + 2, 400);
    check("overrun_pulse", overrun, 1);
    out_ready = 1'b1;
    @(negedge clk_12); #1;
    check("overrun_width", overrun, 0);
    check("valid_cleared", out_valid, 0);
    check("overrun_count", ovr_cnt - ov0, 1);

    // Disable mid left slot (bit_cnt=10).
    wait_level(1, 1'b1, 300, t0);
    wait_level(1, 1'b0, 300, t0);
    repeat (40) @(negedge clk_12);
    #1;
    enable = 1'b0;
    pc0 = pub_cnt;
    @(negedge clk_12); #1;
    check("dis_bclk", bclk, 0);
    check("dis_lrck", lrck, 0);
    stim_q.push_back(5);
    repeat (300) @(negedge clk_12);
    #1;
    check("dis_no_pair", pub_cnt, pc0);
    enable = 1'b1;
    c = cyc;
    wait_pubs(pc0 + 1, 400);
    check("reenable_latency", pub_cyc_q[pub_cyc_q.size()-1] - c, 195);

    // Async reset mid right slot while a pair is held.
    out_ready = 1'b0;
    wait_pubs(pub_cnt + 1, 400);
    wait_level(1, 1'b0, 300, t0);
    wait_level(1, 1'b1, 300, t0);
    repeat (30) @(negedge clk_12);
    #1;
    check("valid_before_rst", out_valid, 1);
    stim_q.push_back(1);
    reset_n = 1'b0;
    #1;
    check("arst_bclk", bclk, 0);
    check("arst_lrck", lrck, 0);
    check("arst_valid", out_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_left", 32'(left_out), 0);
    check("arst_right", 32'(right_out), 0);
    repeat (5) @(negedge clk_12);
    #1;
    out_ready = 1'b1;
    reset_n   = 1'b1;
    c  = cyc;
    pc0 = pub_cnt;
    wait_pubs(pc0 + 1, 400);
    check("post_rst_latency", pub_cyc_q[pub_cyc_q.size()-1] - c, 195);

    enable = 1'b0;
    repeat (10) @(negedge clk_12);
    #1;
    check("pending_pairs", exp_q.size(), 0);
    check("end_valid", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
